// File: rtl/nw_xbar_select_alloc_pkg.sv
// Shared constants and helpers for the crossbar select allocator.
package nw_xbar_select_alloc_pkg;

  localparam int unsigned NDefault = 4;

  // Width of a port index; never zero so a 1-port build still has a legal vector.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nw_xbar_select_alloc_if.sv
// Flit-side requests and crossbar-side selects between input FIFOs and the allocator.
interface nw_xbar_select_alloc_if
  import nw_xbar_select_alloc_pkg::*;
#(
  parameter int unsigned N = NDefault
);

  logic [N-1:0]        in_valid;
  logic [N-1:0][N-1:0] in_dest;
  logic [N-1:0]        in_tail;
  logic [N-1:0]        out_ready;
  logic [N-1:0][N-1:0] xbar_select;
  logic [N-1:0]        in_grant;
  logic [N-1:0]        in_xfer;

  modport master (
    output in_valid, in_dest, in_tail, out_ready,
    input  xbar_select, in_grant, in_xfer
  );

  modport slave (
    input  in_valid, in_dest, in_tail, out_ready,
    output xbar_select, in_grant, in_xfer
  );

endinterface

// File: rtl/nw_xbar_select_alloc_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner
// only when the caller enables an update.
module nw_xbar_select_alloc_rr_arbiter
  import nw_xbar_select_alloc_pkg::*;
#(
  parameter int unsigned N = NDefault
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned IdxW = idx_w(N);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] win;
  logic            found;
  int unsigned     idx;

  always_comb begin
    gnt_o = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    // Scan ptr, ptr+1, ... with wrap; first requester wins.
    for (int k = 0; k < int'(N); k++) begin
      idx = (32'(ptr_q) + 32'(k)) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        win        = IdxW'(idx);
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && found) begin
      ptr_d = (win == IdxW'(N - 1)) ? '0 : win + IdxW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/nw_xbar_select_alloc.sv
// Per-output round-robin allocation with wormhole locking; drives the one-hot select
// matrix of the crossbar and the per-input pop strobe.
module nw_xbar_select_alloc
  import nw_xbar_select_alloc_pkg::*;
#(
  parameter int unsigned N = NDefault
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nw_xbar_select_alloc_if.slave   bus
);

  logic [N-1:0][N-1:0] sel_q, sel_d;
  logic [N-1:0][N-1:0] sel_t;
  logic [N-1:0][N-1:0] req;
  logic [N-1:0][N-1:0] arb_gnt;
  logic [N-1:0]        grant;
  logic [N-1:0]        ready_sel;
  logic [N-1:0]        xfer;
  logic [N-1:0]        row_busy;
  logic [N-1:0]        row_release;
  logic [N-1:0]        arb_en;

  always_comb begin
    grant     = '0;
    ready_sel = '0;
    sel_t     = '0;
    for (int o = 0; o < int'(N); o++) begin
      for (int i = 0; i < int'(N); i++) begin
        grant[i]     = grant[i] | sel_q[o][i];
        ready_sel[i] = ready_sel[i] | (sel_q[o][i] & bus.out_ready[o]);
        sel_t[i][o]  = sel_q[o][i];
      end
    end
    xfer = ready_sel & bus.in_valid;
  end

  // Any granted input is either held or releasing, so it never requests elsewhere.
  always_comb begin
    req = '0;
    for (int o = 0; o < int'(N); o++) begin
      for (int i = 0; i < int'(N); i++) begin
        req[o][i] = bus.in_valid[i] & bus.in_dest[i][o] & ~grant[i];
      end
    end
  end

  always_comb begin
    sel_d = sel_q;
    for (int o = 0; o < int'(N); o++) begin
      row_busy[o]    = |sel_q[o];
      row_release[o] = |(sel_q[o] & xfer & bus.in_tail);
      arb_en[o]      = ~row_busy[o] | row_release[o];
      if (arb_en[o]) begin
        sel_d[o] = arb_gnt[o];
      end
    end
  end

  for (genvar g = 0; g < int'(N); g++) begin : g_arb
    nw_xbar_select_alloc_rr_arbiter #(
      .N (N)
    ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (req[g]),
      .en_i  (arb_en[g]),
      .gnt_o (arb_gnt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign bus.xbar_select = sel_q;
  assign bus.in_grant    = grant;
  assign bus.in_xfer     = xfer;

  for (genvar g = 0; g < int'(N); g++) begin : g_chk
    a_row_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(sel_q[g]));
    a_col_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(sel_t[g]));
    a_dest_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      bus.in_valid[g] |-> $onehot0(bus.in_dest[g]));
    a_dest_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (grant[g] && !(xfer[g] && bus.in_tail[g])) |=> $stable(bus.in_dest[g]));
  end

endmodule

// File: tb/tb_nw_xbar_select_alloc.sv
// Directed bench for the crossbar select allocator; expected select/xfer pushed per cycle.
module tb_nw_xbar_select_alloc;

  typedef struct packed {
    logic [15:0] sel;
    logic [3:0]  xfer;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  nw_xbar_select_alloc_if #(.N(4)) bus ();

  nw_xbar_select_alloc #(
    .N (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [3:0] grant_of(input logic [15:0] s);
    logic [3:0] g;
    g = '0;
    for (int o = 0; o < 4; o++) g = g | s[4*o +: 4];
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sel"},   32'(bus.xbar_select), 32'(e.sel));
      chk({tag, "_xfer"},  32'(bus.in_xfer),     32'(e.xfer));
      chk({tag, "_grant"}, 32'(bus.in_grant),    32'(grant_of(e.sel)));
    end
  endtask

  task automatic cyc(input logic [15:0] es, input logic [3:0] ex, input string tag);
    exp_q.push_back('{sel: es, xfer: ex});
    @(negedge clk);
    check_now(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_dest   = '0;
    bus.in_tail   = '0;
    bus.out_ready = 4'hF;

    cyc(16'h0000, 4'b0000, "reset");
    cyc(16'h0000, 4'b0000, "reset");
    rst_n = 1'b1;

    repeat (10) cyc(16'h0000, 4'b0000, "idle");

    // valid with an empty destination is not a request
    bus.in_valid = 4'b0001;
    cyc(16'h0000, 4'b0000, "dest_zero");
    cyc(16'h0000, 4'b0000, "dest_zero");
    bus.in_valid = '0;

    // single-flit packets, input 2 -> output 1, then same input again
    bus.in_dest[2] = 4'b0010;
    bus.in_tail    = 4'b0100;
    bus.in_valid   = 4'b0100;
    cyc(16'h0000, 4'b0000, "single_req");
    cyc(16'h0040, 4'b0100, "single_grant");
    cyc(16'h0000, 4'b0000, "single_gap");
    cyc(16'h0040, 4'b0100, "single_regrant");
    bus.in_valid = '0;
    cyc(16'h0000, 4'b0000, "single_idle");

    // inputs 0, 1, 3 contend for output 0
    bus.in_dest[0] = 4'b0001;
    bus.in_dest[1] = 4'b0001;
    bus.in_dest[3] = 4'b0001;
    bus.in_tail    = 4'b1111;
    bus.in_valid   = 4'b1011;
    cyc(16'h0000, 4'b0000, "cont_req");
    cyc(16'h0001, 4'b0001, "cont_g0");
    cyc(16'h0002, 4'b0010, "cont_g1");
    cyc(16'h0008, 4'b1000, "cont_g3");
    bus.in_valid = 4'b0001;
    cyc(16'h0001, 4'b0001, "cont_g0b");
    bus.in_valid = '0;
    cyc(16'h0000, 4'b0000, "cont_idle");

    // 4-flit wormhole from input 1 to output 3, input 0 waiting, backpressure mid-packet
    bus.in_dest[1] = 4'b1000;
    bus.in_tail    = 4'b0000;
    bus.in_valid   = 4'b0010;
    cyc(16'h0000, 4'b0000, "wh_req");
    bus.in_dest[0] = 4'b1000;
    bus.in_tail    = 4'b0001;
    bus.in_valid   = 4'b0011;
    cyc(16'h2000, 4'b0010, "wh_f1");
    cyc(16'h2000, 4'b0010, "wh_f2");
    bus.out_ready = 4'b0111;
    repeat (5) cyc(16'h2000, 4'b0000, "bp_hold");
    bus.out_ready = 4'b1111;
    cyc(16'h2000, 4'b0010, "wh_f3");
    bus.in_tail = 4'b0011;
    cyc(16'h2000, 4'b0010, "wh_tail");
    bus.in_valid = 4'b0001;
    cyc(16'h1000, 4'b0001, "wh_next");
    bus.in_valid = '0;
    cyc(16'h0000, 4'b0000, "wh_idle");

    // full permutation, then asynchronous reset mid-packet
    bus.in_dest[0] = 4'b1000;
    bus.in_dest[1] = 4'b0100;
    bus.in_dest[2] = 4'b0010;
    bus.in_dest[3] = 4'b0001;
    bus.in_tail    = 4'b0000;
    bus.in_valid   = 4'b1111;
    cyc(16'h0000, 4'b0000, "perm_req");
    cyc(16'h1248, 4'b1111, "perm_all");
    cyc(16'h1248, 4'b1111, "perm_hold");
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back('{sel: 16'h0000, xfer: 4'b0000});
    check_now("rst_async");
    bus.in_valid   = '0;
    bus.in_dest[1] = 4'b1000;
    bus.in_tail    = 4'b0011;
    cyc(16'h0000, 4'b0000, "rst_hold");
    rst_n = 1'b1;

    // pointer for output 3 must restart at 0, so input 0 beats input 1
    bus.in_valid = 4'b0011;
    cyc(16'h0000, 4'b0000, "rr_req");
    cyc(16'h1000, 4'b0001, "rr_ptr0");
    bus.in_valid = 4'b0010;
    cyc(16'h2000, 4'b0010, "rr_next");
    bus.in_valid = '0;
    cyc(16'h0000, 4'b0000, "rr_idle");

    if (exp_q.size() != 0) chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
